code_lock_ctrl: RTL and testbench

Parametrised keypad combination-lock controller. It accepts digits serially, holds the secret code internally and compares it on `enter`, so no external `match` is needed. It also counts failed attempts up to a configurable alarm threshold, times the unlock pulse, and supports an in-field code change. It sits between the keypad scanner and the door actuator/alarm driver in the home-security datapath.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/lock_digit_buf.sv | 48 ++++
 rtl/code_lock_ctrl.sv | 122 ++++++++++++
 tb/tb_code_lock_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and counter-width helpers for the keypad code lock.
package lock_pkg;

    typedef enum logic [1:0] {IDLE, OPEN, NEWC, ALARM} lock_state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned digits);
        return bits_for(digits);
    endfunction

    function automatic int unsigned timer_width(input int unsigned open_cycles);
        return bits_for(open_cycles - 1);
    endfunction

    function automatic int unsigned fails_width(input int unsigned max_tries);
        return bits_for(max_tries);
    endfunction

endpackage

// File: rtl/lock_digit_buf.sv
// Digit shift buffer: newest digit enters the LSBs, so digit 0 ends up in the MSBs.
module lock_digit_buf
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       clr,
    input  logic                       shift,
    input  logic [DIGIT_W-1:0]         digit,
    output logic [DIGITS*DIGIT_W-1:0]  data,
    output logic                       full
);

    localparam int unsigned DW = DIGITS * DIGIT_W;
    localparam int unsigned CW = cnt_width(DIGITS);

    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift && !full) begin
            data_d = (data_q << DIGIT_W) | DW'(digit);
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data = data_q;
    assign full = (cnt_q == CW'(DIGITS));

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad combination-lock controller: code check, failure count/alarm, timed unlock,
// and in-field code change.
module code_lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned                   DIGITS      = 4,
    parameter int unsigned                   DIGIT_W     = 4,
    parameter int unsigned                   MAX_TRIES   = 3,
    parameter int unsigned                   OPEN_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0]     RESET_CODE  = '0
) (
    input  logic                             Clock,
    input  logic                             Resetn,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic                             change,
    output logic                             open,
    output logic                             alarm,
    output logic                             neww,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int unsigned DW = DIGITS * DIGIT_W;
    localparam int unsigned TW = timer_width(OPEN_CYCLES);
    localparam int unsigned FW = fails_width(MAX_TRIES);

    lock_state_t   state_q, state_d;
    logic [DW-1:0] code_q, code_d;
    logic [FW-1:0] fails_q, fails_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [DW-1:0] buf_data;
    logic          buf_full, buf_clr, buf_shift;
    logic          ev_enter, ev_change, match;

    lock_digit_buf #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_buf (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (buf_clr),
        .shift  (buf_shift),
        .digit  (digit),
        .data   (buf_data),
        .full   (buf_full)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fails_d = fails_q;
        timer_d = timer_q;
        buf_clr = 1'b0;

        // enter and change together cancel out and leave the buffer intact
        ev_enter  = enter & ~change;
        ev_change = change & ~enter;
        match     = buf_full && (buf_data == code_q);
        buf_shift = digit_valid & ~enter & ~change & ((state_q == IDLE) || (state_q == NEWC));

        case (state_q)
            IDLE: begin
                if (ev_enter || ev_change) begin
                    buf_clr = 1'b1;
                    if (match) begin
                        fails_d = '0;
                        timer_d = '0;
                        state_d = ev_enter ? OPEN : NEWC;
                    end else if (fails_q == FW'(MAX_TRIES - 1)) begin
                        fails_d = FW'(MAX_TRIES);
                        state_d = ALARM;
                    end else begin
                        fails_d = fails_q + 1'b1;
                    end
                end
            end
            OPEN: begin
                if (ev_enter || (timer_q == TW'(OPEN_CYCLES - 1))) begin
                    state_d = IDLE;
                    buf_clr = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            NEWC: begin
                if (ev_enter) begin
                    buf_clr = 1'b1;
                    state_d = IDLE;
                    if (buf_full) code_d = buf_data;
                end else if (ev_change) begin
                    buf_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            ALARM: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            code_q  <= RESET_CODE;
            fails_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fails_q <= fails_d;
            timer_q <= timer_d;
        end
    end

    assign open       = (state_q == OPEN);
    assign alarm      = (state_q == ALARM);
    assign neww       = (state_q == NEWC);
    assign tries_left = FW'(MAX_TRIES) - fails_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: expected {open,alarm,neww,tries_left} queued per cycle.
module tb_code_lock_ctrl;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       change = 1'b0;
    logic       open, alarm, neww;
    logic [1:0] tries_left;

    int checks = 0;
    int errors = 0;

    logic       e_open, e_alarm, e_neww;
    logic [1:0] e_tries;

    string      tag_q[$];
    logic [4:0] exp_q[$];

    code_lock_ctrl #(
        .DIGITS      (4),
        .DIGIT_W     (4),
        .MAX_TRIES   (3),
        .OPEN_CYCLES (8),
        .RESET_CODE  (16'h1234)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .digit_valid (digit_valid),
        .digit       (digit),
        .enter       (enter),
        .change      (change),
        .open        (open),
        .alarm       (alarm),
        .neww        (neww),
        .tries_left  (tries_left)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {open, alarm, neww, tries_left};
    endfunction

    // Monitor: compare the outputs produced by the edge that sampled each queued stimulus
    always @(posedge Clock) begin
        string      t;
        logic [4:0] e;
        #2;
        if (exp_q.size() != 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, 32'(outs()), 32'(e));
        end
    end

    task automatic drive(input logic dv, input logic [3:0] d, input logic en, input logic ch,
                         input string tag);
        @(negedge Clock);
        digit_valid = dv;
        digit       = d;
        enter       = en;
        change      = ch;
        tag_q.push_back(tag);
        exp_q.push_back({e_open, e_alarm, e_neww, e_tries});
        @(posedge Clock);
        #1;
        digit_valid = 1'b0;
        enter       = 1'b0;
        change      = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0, "digit");
    endtask

    task automatic press4(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
    endtask

    task automatic key_enter(input string tag);
        drive(1'b0, 4'd0, 1'b1, 1'b0, tag);
    endtask

    task automatic key_change(input string tag);
        drive(1'b0, 4'd0, 1'b0, 1'b1, tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 4'd0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clock);
        #1 Resetn = 1'b0;
        #1 check_eq(tag, 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 2'd3}));
        @(negedge Clock);
        Resetn  = 1'b1;
        e_open  = 1'b0;
        e_alarm = 1'b0;
        e_neww  = 1'b0;
        e_tries = 2'd3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        e_open  = 1'b0;
        e_alarm = 1'b0;
        e_neww  = 1'b0;
        e_tries = 2'd3;
        repeat (2) @(negedge Clock);
        check_eq("reset_state", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 2'd3}));
        Resetn = 1'b1;

        // Correct code opens for exactly 8 cycles
        press4(16'h1234);
        e_open = 1'b1;
        key_enter("open_start");
        for (int i = 0; i < 7; i++) idle("open_hold");
        e_open = 1'b0;
        idle("open_end");

        // Three failures trip a sticky alarm
        press4(16'h1235);
        e_tries = 2'd2;
        key_enter("fail1");
        press4(16'h1235);
        e_tries = 2'd1;
        key_enter("fail2");
        press4(16'h1235);
        e_tries = 2'd0;
        e_alarm = 1'b1;
        key_enter("fail3_alarm");
        press(4'd1);
        key_enter("alarm_enter");
        key_change("alarm_change");
        idle("alarm_hold");
        do_reset("alarm_reset");

        // Code change to 9876
        press4(16'h1234);
        e_neww = 1'b1;
        key_change("newc_enter");
        press4(16'h9876);
        e_neww = 1'b0;
        key_enter("newc_commit");
        press4(16'h1234);
        e_tries = 2'd2;
        key_enter("old_code_fails");
        press4(16'h9876);
        e_tries = 2'd3;
        e_open  = 1'b1;
        key_enter("new_code_opens");
        e_open = 1'b0;
        key_enter("relock");
        do_reset("reset_after_change");

        // Short code fails; overlong code drops the fifth digit
        press(4'd1);
        press(4'd2);
        press(4'd3);
        e_tries = 2'd2;
        key_enter("short_code");
        press4(16'h1234);
        press(4'd5);
        e_tries = 2'd3;
        e_open  = 1'b1;
        key_enter("overlong_opens");
        e_open = 1'b0;
        key_enter("relock2");

        // Aborted code change keeps the old code and the fail count
        press4(16'h1234);
        e_neww = 1'b1;
        key_change("newc_enter2");
        press(4'd5);
        press(4'd5);
        e_neww = 1'b0;
        key_enter("newc_abort");
        press4(16'h1234);
        e_open = 1'b1;
        key_enter("code_kept");
        e_open = 1'b0;
        key_enter("relock3");

        // enter+change together is a no-op and keeps the buffer
        press(4'd5);
        e_tries = 2'd2;
        key_enter("fail_before_nop");
        press4(16'h1234);
        drive(1'b0, 4'd0, 1'b1, 1'b1, "enter_change_nop");
        e_tries = 2'd3;
        e_open  = 1'b1;
        key_enter("buffer_kept");
        e_open = 1'b0;
        key_enter("relock4");

        // Digit coincident with enter is discarded
        press4(16'h1234);
        e_open = 1'b1;
        drive(1'b1, 4'd5, 1'b1, 1'b0, "digit_with_enter");
        e_open = 1'b0;
        key_enter("relock5");

        // Asynchronous reset mid-OPEN, then mid-entry
        press4(16'h1234);
        e_open = 1'b1;
        key_enter("open_before_reset");
        idle("open_c2");
        idle("open_c3");
        do_reset("reset_mid_open");
        press(4'd1);
        press(4'd2);
        do_reset("reset_mid_entry");
        press4(16'h1234);
        e_open = 1'b1;
        key_enter("open_after_reset");
        for (int i = 0; i < 7; i++) idle("open_hold2");
        e_open = 1'b0;
        idle("open_end2");

        @(negedge Clock);
        @(negedge Clock);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
